// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared trellis definitions for the convolutional encoder and Viterbi decoder
package viterbi_pkg;

    localparam int         K          = 3;
    localparam int         NUM_STATES = 4;
    localparam logic [2:0] G0_DEF     = 3'b111;
    localparam logic [2:0] G1_DEF     = 3'b101;

    // Trellis state is {u(t-1), u(t-2)}, so an input 1 from S0 lands in S2
    typedef logic [1:0] state_t;
    typedef logic [1:0] sym_t;

    localparam state_t S0 = 2'b00;
    localparam state_t S1 = 2'b01;
    localparam state_t S2 = 2'b10;
    localparam state_t S3 = 2'b11;

    typedef enum logic {
        ENC_DATA = 1'b0,
        ENC_TAIL = 1'b1
    } enc_fsm_t;

endpackage

// File: rtl/conv_encoder_tx_if.sv
// rtl/conv_encoder_tx_if.sv - bit-in / symbol-out handshake bundle of the convolutional encoder
interface conv_encoder_tx_if;
    import viterbi_pkg::*;

    logic   i_valid;
    logic   o_ready;
    logic   i_data;
    logic   o_valid;
    logic   i_ready;
    sym_t   o_sym;
    logic   o_tail;
    logic   o_last;
    state_t o_state;

    // Encoder side
    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_sym, o_tail, o_last, o_state
    );

    // Bit source and symbol sink side
    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_sym, o_tail, o_last, o_state
    );

endinterface

// File: rtl/conv_trellis_fn.sv
// rtl/conv_trellis_fn.sv - combinational trellis step (state, u) -> (next_state, sym)
module conv_trellis_fn
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0 = G0_DEF,
    parameter logic [2:0] G1 = G1_DEF
) (
    input  state_t state,
    input  logic   u,
    output state_t next_state,
    output sym_t   sym
);

    // Shift register contents in tap order {u(t), u(t-1), u(t-2)}
    logic [2:0] reg_bits;

    assign reg_bits   = {u, state};
    assign sym        = {^(G0 & reg_bits), ^(G1 & reg_bits)};
    assign next_state = {u, state[1]};

endmodule

// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 K=3 convolutional encoder with zero-tail frame termination
module conv_encoder_tx
    import viterbi_pkg::*;
#(
    parameter int         FRAME_LEN = 8,
    parameter logic [2:0] G0        = G0_DEF,
    parameter logic [2:0] G1        = G1_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    conv_encoder_tx_if.slave bus
);

    localparam int               CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    enc_fsm_t         fsm;
    logic [CNT_W-1:0] bit_cnt;
    logic             tail_cnt;
    state_t           state_q;

    logic             slot_free;
    logic             u_in;
    state_t           next_state;
    sym_t             sym_next;

    // The output register can take a new symbol when empty or being drained this cycle
    assign slot_free   = !bus.o_valid || bus.i_ready;
    assign bus.o_ready = (fsm == ENC_DATA) && slot_free;
    assign bus.o_state = state_q;

    // Tail bits are forced zero so every frame flushes back to S0
    assign u_in = (fsm == ENC_DATA) ? bus.i_data : 1'b0;

    conv_trellis_fn #(
        .G0 (G0),
        .G1 (G1)
    ) u_trellis (
        .state      (state_q),
        .u          (u_in),
        .next_state (next_state),
        .sym        (sym_next)
    );

    // Frame FSM, counters and output register all advance only while the output slot is free
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm         <= ENC_DATA;
            bit_cnt     <= '0;
            tail_cnt    <= 1'b0;
            state_q     <= S0;
            bus.o_valid <= 1'b0;
            bus.o_sym   <= '0;
            bus.o_tail  <= 1'b0;
            bus.o_last  <= 1'b0;
        end else if (slot_free) begin
            case (fsm)
                ENC_DATA: begin
                    if (bus.i_valid) begin
                        bus.o_valid <= 1'b1;
                        bus.o_sym   <= sym_next;
                        bus.o_tail  <= 1'b0;
                        bus.o_last  <= 1'b0;
                        state_q     <= next_state;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            fsm     <= ENC_TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        bus.o_valid <= 1'b0;
                    end
                end
                ENC_TAIL: begin
                    bus.o_valid <= 1'b1;
                    bus.o_sym   <= sym_next;
                    bus.o_tail  <= 1'b1;
                    bus.o_last  <= tail_cnt;
                    state_q     <= next_state;
                    tail_cnt    <= ~tail_cnt;
                    if (tail_cnt) begin
                        fsm <= ENC_DATA;
                    end
                end
                default: fsm <= ENC_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - self-checking bench for conv_encoder_tx with FRAME_LEN 8, 2 and 1
module tb_conv_encoder_tx;
    import viterbi_pkg::*;

    localparam int NL = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid [NL];
    logic       in_data  [NL];
    logic       out_ready[NL];
    logic       rdy      [NL];
    logic       vld      [NL];
    logic       tl       [NL];
    logic       lst      [NL];
    logic [1:0] sym_w    [NL];
    logic [1:0] st_w     [NL];

    int checks = 0;
    int errors = 0;
    int stall_cnt;
    logic done1;

    int known_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int imp_bits  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int zero_bits [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int k_sym  [10] = '{3, 2, 0, 1, 1, 3, 3, 2, 3, 0};
    int k_st   [10] = '{2, 1, 2, 3, 1, 0, 2, 1, 0, 0};
    int imp_sym[10] = '{3, 2, 3, 0, 0, 0, 0, 0, 0, 0};
    int imp_st [10] = '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int zero10 [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int f1_sym [10] = '{3, 2, 3, 0, 0, 0, 3, 2, 3, 0};
    int f1_st  [10] = '{2, 1, 0, 0, 0, 0, 2, 1, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Expected {sym, tail, last, state}: (7,5) code means c0 = u+u1+u2, c1 = u+u2 (mod 2)
    function automatic logic [5:0] model_sym(input int u, input int u1, input int u2,
                                             input logic tl_f, input logic ls_f);
        logic c0, c1;
        c0 = ((u + u1 + u2) % 2) == 1;
        c1 = ((u + u2) % 2) == 1;
        return {c0, c1, tl_f, ls_f, u == 1, u1 == 1};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int FL = (g == 0) ? 8 : ((g == 1) ? 2 : 1);

        conv_encoder_tx_if bus ();

        conv_encoder_tx #(.FRAME_LEN(FL)) dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus)
        );

        assign bus.i_valid = in_valid[g];
        assign bus.i_data  = in_data[g];
        assign bus.i_ready = out_ready[g];
        assign rdy[g]      = bus.o_ready;
        assign vld[g]      = bus.o_valid;
        assign tl[g]       = bus.o_tail;
        assign lst[g]      = bus.o_last;
        assign sym_w[g]    = bus.o_sym;
        assign st_w[g]     = bus.o_state;

        logic [5:0] exp_q[$];
        logic [5:0] obs[$];
        int u1 = 0;
        int u2 = 0;
        int pos = 0;
        int consumed = 0;
        int lasts = 0;

        always @(negedge clk) begin
            logic [5:0] act;
            int u;
            if (rst) begin
                exp_q.delete();
                u1  = 0;
                u2  = 0;
                pos = 0;
            end else begin
                if (bus.o_valid && bus.i_ready) begin
                    act = {bus.o_sym, bus.o_tail, bus.o_last, bus.o_state};
                    obs.push_back(act);
                    consumed++;
                    if (bus.o_last) lasts++;
                    if (exp_q.size() == 0)
                        chk($sformatf("lane%0d unexpected symbol", g), int'(act), -1);
                    else
                        chk($sformatf("lane%0d model symbol %0d", g, consumed), int'(act), int'(exp_q.pop_front()));
                    if (bus.o_last)
                        chk($sformatf("lane%0d state after tail", g), int'(bus.o_state), 0);
                end
                if (bus.i_valid && bus.o_ready) begin
                    u = int'(bus.i_data);
                    exp_q.push_back(model_sym(u, u1, u2, 1'b0, 1'b0));
                    u2 = u1;
                    u1 = u;
                    pos++;
                    if (pos == FL) begin
                        exp_q.push_back(model_sym(0, u1, u2, 1'b1, 1'b0));
                        u2 = u1;
                        u1 = 0;
                        exp_q.push_back(model_sym(0, u1, u2, 1'b1, 1'b1));
                        u2 = u1;
                        u1 = 0;
                        pos = 0;
                    end
                end
            end
        end
    end

    function automatic int obs_size(input int g);
        case (g)
            0:       return lane[0].obs.size();
            1:       return lane[1].obs.size();
            default: return lane[2].obs.size();
        endcase
    endfunction

    function automatic logic [5:0] get_obs(input int g, input int i);
        case (g)
            0:       return lane[0].obs[i];
            1:       return lane[1].obs[i];
            default: return lane[2].obs[i];
        endcase
    endfunction

    task automatic obs_clear(input int g);
        case (g)
            0:       lane[0].obs.delete();
            1:       lane[1].obs.delete();
            default: lane[2].obs.delete();
        endcase
    endtask

    // Offer one bit, hold it until accepted, return just after the accepting edge
    task automatic send(input int g, input logic d);
        int t;
        logic ok;
        t = 0;
        in_valid[g] = 1'b1;
        in_data[g]  = d;
        forever begin
            @(negedge clk);
            ok = rdy[g];
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 200) begin
                chk($sformatf("lane%0d send timeout", g), 1, 0);
                break;
            end
        end
        in_valid[g] = 1'b0;
    endtask

    task automatic send_frame8(input int bits[8]);
        for (int i = 0; i < 8; i++) send(0, bits[i][0]);
    endtask

    task automatic drain(input int g);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (vld[g] && t < 100);
        chk($sformatf("lane%0d drain timeout", g), int'(t >= 100), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int g, input int fl, input int n,
                             input int es[10], input int est[10]);
        logic [5:0] o;
        chk({tag, " count"}, obs_size(g), n);
        if (obs_size(g) >= n) begin
            for (int i = 0; i < n; i++) begin
                o = get_obs(g, i);
                chk($sformatf("%s sym[%0d]", tag, i), int'(o[5:4]), es[i % 10]);
                chk($sformatf("%s tail[%0d]", tag, i), int'(o[3]), int'((i % (fl + 2)) >= fl));
                chk($sformatf("%s last[%0d]", tag, i), int'(o[2]), int'((i % (fl + 2)) == fl + 1));
                chk($sformatf("%s state[%0d]", tag, i), int'(o[1:0]), est[i % 10]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < NL; g++) begin
            in_valid[g]  = 1'b0;
            in_data[g]   = 1'b0;
            out_ready[g] = 1'b1;
        end
        done1 = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("reset o_valid", vld[0], 0);
        chk("reset o_sym",   sym_w[0], 0);
        chk("reset o_tail",  tl[0], 0);
        chk("reset o_last",  lst[0], 0);
        chk("reset o_state", st_w[0], 0);
        chk("reset o_ready", rdy[0], 1);
        @(posedge clk);
        #1;

        obs_clear(0);
        send_frame8(known_bits);
        drain(0);
        check_seq("known", 0, 8, 10, k_sym, k_st);

        obs_clear(0);
        send_frame8(imp_bits);
        drain(0);
        check_seq("impulse", 0, 8, 10, imp_sym, imp_st);

        obs_clear(0);
        send_frame8(zero_bits);
        drain(0);
        check_seq("zero", 0, 8, 10, zero10, zero10);

        obs_clear(0);
        fork
            send_frame8(known_bits);
            begin
                int t;
                t = 0;
                while (!(vld[0] && obs_size(0) == 2) && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("backpressure start timeout", int'(t >= 100), 0);
                out_ready[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall o_valid", vld[0], 1);
                    chk("stall o_sym",   sym_w[0], 0);
                    chk("stall o_ready", rdy[0], 0);
                    chk("stall o_state", st_w[0], 2);
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        drain(0);
        check_seq("backpressure", 0, 8, 10, k_sym, k_st);

        obs_clear(0);
        stall_cnt = 0;
        fork
            begin
                send_frame8(known_bits);
                send_frame8(known_bits);
            end
            repeat (30) begin
                @(negedge clk);
                if (in_valid[0] && !rdy[0]) stall_cnt++;
            end
        join
        drain(0);
        chk("tail stall cycles", stall_cnt, 2);
        check_seq("two frames", 0, 8, 20, k_sym, k_st);

        for (int i = 0; i < 3; i++) send(0, known_bits[i][0]);
        rst = 1'b1;
        #1;
        chk("mid-reset o_valid", vld[0], 0);
        chk("mid-reset o_state", st_w[0], 0);
        chk("mid-reset o_sym",   sym_w[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_clear(0);
        send_frame8(known_bits);
        drain(0);
        check_seq("after reset", 0, 8, 10, k_sym, k_st);

        obs_clear(2);
        send(2, 1'b1);
        send(2, 1'b0);
        send(2, 1'b1);
        drain(2);
        check_seq("frame_len1", 2, 1, 9, f1_sym, f1_st);

        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    for (int b = 0; b < 2; b++) begin
                        send(1, 1'($urandom_range(0, 1)));
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                done1 = 1'b1;
            end
            while (!done1) begin
                @(posedge clk);
                #1;
                out_ready[1] = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready[1] = 1'b1;
        drain(1);
        chk("random symbols consumed", lane[1].consumed, 80);
        chk("random frame ends",       lane[1].lasts, 20);
        chk("random model leftovers",  lane[1].exp_q.size(), 0);
        chk("lane0 model leftovers",   lane[0].exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
